// File: rtl/grn_node_multi_pkg.sv
// Shared defaults and types for the multi-channel GRN node.
// Default sizes match the network top; the enum names one channel's per-cycle action.
package grn_node_multi_pkg;

    localparam int unsigned DefWidth   = 1;
    localparam int unsigned DefNch     = 2;
    localparam int unsigned DefPeriodW = 2;

    typedef enum logic [1:0] {
        ActHold,
        ActInit,
        ActLoad,
        ActSkip
    } chan_act_e;

endpackage

// File: rtl/grn_node_chan.sv
// One GRN node state channel.
// It loads next_in on a start pulse, then skips the next `period` start pulses.
module grn_node_chan
    import grn_node_multi_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned PERIOD_W = DefPeriodW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reset_nos,
    input  logic [WIDTH-1:0]    init_state,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    input  logic [WIDTH-1:0]    next_in,
    output logic [WIDTH-1:0]    s,
    output logic                upd,
    output logic                chg,
    output logic                seen,
    output logic                chg_next,
    output logic                seen_next
);

    logic [WIDTH-1:0]    s_q, s_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                upd_q, upd_d;
    logic                chg_q, chg_d;
    logic                seen_q, seen_d;
    chan_act_e           act;

    always_comb begin
        act = ActHold;
        if (reset_nos) begin
            act = ActInit;
        end else if (start) begin
            act = (cnt_q == '0) ? ActLoad : ActSkip;
        end
    end

    always_comb begin
        s_d    = s_q;
        cnt_d  = cnt_q;
        upd_d  = 1'b0;
        chg_d  = chg_q;
        seen_d = seen_q;
        unique case (act)
            ActInit: begin
                s_d    = init_state;
                cnt_d  = '0;
                chg_d  = 1'b0;
                seen_d = 1'b0;
            end
            ActLoad: begin
                s_d    = next_in;
                cnt_d  = period;
                upd_d  = 1'b1;
                chg_d  = (next_in != s_q);
                seen_d = 1'b1;
            end
            ActSkip: begin
                // cnt_q is nonzero here, so this cannot wrap
                cnt_d = cnt_q - PERIOD_W'(1);
            end
            ActHold: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cnt_q  <= '0;
            upd_q  <= 1'b0;
            chg_q  <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            upd_q  <= upd_d;
            chg_q  <= chg_d;
            seen_q <= seen_d;
        end
    end

    assign s         = s_q;
    assign upd       = upd_q;
    assign chg       = chg_q;
    assign seen      = seen_q;
    assign chg_next  = chg_d;
    assign seen_next = seen_d;

endmodule

// File: rtl/grn_node_multi.sv
// GRN node with NCH independently clocked-down state channels.
// A node-level stable flag marks when every channel has loaded and none changed on its last load.
module grn_node_multi
    import grn_node_multi_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned NCH      = DefNch,
    parameter int unsigned PERIOD_W = DefPeriodW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    reset_nos,
    input  logic [WIDTH-1:0]        init_state,
    input  logic [NCH-1:0]          start,
    input  logic [NCH*PERIOD_W-1:0] period,
    input  logic [NCH*WIDTH-1:0]    next_in,
    output logic [NCH*WIDTH-1:0]    s,
    output logic [NCH-1:0]          upd,
    output logic [NCH-1:0]          chg,
    output logic                    stable
);

    logic [NCH-1:0] seen;
    logic [NCH-1:0] chg_next;
    logic [NCH-1:0] seen_next;
    logic           stable_q, stable_d;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        grn_node_chan #(
            .WIDTH    (WIDTH),
            .PERIOD_W (PERIOD_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .reset_nos  (reset_nos),
            .init_state (init_state),
            .start      (start[c]),
            .period     (period[c*PERIOD_W +: PERIOD_W]),
            .next_in    (next_in[c*WIDTH +: WIDTH]),
            .s          (s[c*WIDTH +: WIDTH]),
            .upd        (upd[c]),
            .chg        (chg[c]),
            .seen       (seen[c]),
            .chg_next   (chg_next[c]),
            .seen_next  (seen_next[c])
        );
    end

    // Built from next-state values so stable lines up with s/upd/chg
    assign stable_d = (&seen_next) & ~(|chg_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule
